// File: rtl/uart_upg_loader_pkg.sv
// Shared types and constants for the UART upgrade loader.
// Frame states, target codes and upgrade bus widths.
package upg_pkg;

   localparam int UPG_ADDR_W = 15;
   localparam int UPG_DATA_W = 32;

   localparam logic [7:0] UPG_TGT_IMEM = 8'h00;
   localparam logic [7:0] UPG_TGT_DMEM = 8'h01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CNT_LO,
      ST_CNT_HI,
      ST_DATA,
      ST_DONE,
      ST_ERR
   } upg_state_e;

endpackage

// File: rtl/uart_upg_loader_if.sv
// Upgrade-port bundle driven by the loader toward the memories.
// The loader owns the master side; observers take the slave side.
interface uart_upg_loader_if;
   import upg_pkg::*;

   logic                  wen;
   logic [UPG_ADDR_W-1:0] addr;
   logic [UPG_DATA_W-1:0] dat;
   logic                  done;
   logic                  err;
   logic                  busy;

   modport master (output wen, addr, dat, done, err, busy);
   modport slave  (input  wen, addr, dat, done, err, busy);

endinterface

// File: rtl/uart_upg_loader_timeout.sv
// Idle-cycle counter guarding the gaps between bytes of a frame.
// Clear wins over enable; expired fires on the cycle that would reach the limit.
module upg_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] TOP  = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear on activity, otherwise count up and saturate.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && cnt_q != TOP) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign expired = en_i && !clr_i && (cnt_q >= LAST);

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_upg_loader.sv
// Byte-stream frame parser producing word writes on the upgrade ports.
// Frame: target, 16-bit LE word count, then N little-endian words.
module uart_upg_loader
   import upg_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter int unsigned MAX_WORDS      = 4096
) (
   input  logic                  upg_clk_i,
   input  logic                  upg_rstn_i,
   input  logic                  rx_valid_i,
   input  logic [7:0]            rx_data_i,
   output logic                  upg_wen_o,
   output logic [UPG_ADDR_W-1:0] upg_addr_o,
   output logic [UPG_DATA_W-1:0] upg_dat_o,
   output logic                  upg_done_o,
   output logic                  err_o,
   output logic                  busy_o
);

   upg_state_e state_q, state_d;
   logic       tgt_q, tgt_d;
   logic [7:0] cnt_lo_q, cnt_lo_d;
   logic [12:0] rem_q, rem_d;
   logic [13:0] addr_q, addr_d;
   logic [1:0] idx_q, idx_d;
   logic [23:0] asm_q, asm_d;
   logic       wen_q, wen_d;
   logic [UPG_ADDR_W-1:0] waddr_q, waddr_d;
   logic [UPG_DATA_W-1:0] dat_q, dat_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       busy_q, busy_d;

   logic        in_frame;
   logic        expired;
   logic [15:0] n_words;

   assign in_frame = (state_q == ST_CNT_LO) || (state_q == ST_CNT_HI) ||
                     (state_q == ST_DATA);
   assign n_words  = {rx_data_i, cnt_lo_q};

   upg_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_tmo (
      .clk_i  (upg_clk_i),
      .rst_ni (upg_rstn_i),
      .clr_i  (rx_valid_i || !in_frame),
      .en_i   (in_frame),
      .expired(expired)
   );

   // Frame parsing: next state, word assembly and write strobe.
   always_comb begin
      state_d  = state_q;
      tgt_d    = tgt_q;
      cnt_lo_d = cnt_lo_q;
      rem_d    = rem_q;
      addr_d   = addr_q;
      idx_d    = idx_q;
      asm_d    = asm_q;
      waddr_d  = waddr_q;
      dat_d    = dat_q;
      wen_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (rx_valid_i && (rx_data_i == UPG_TGT_IMEM ||
                               rx_data_i == UPG_TGT_DMEM)) begin
               tgt_d   = rx_data_i[0];
               state_d = ST_CNT_LO;
            end
         end
         ST_CNT_LO: begin
            if (rx_valid_i) begin
               cnt_lo_d = rx_data_i;
               state_d  = ST_CNT_HI;
            end else if (expired) begin
               state_d = ST_ERR;
            end
         end
         ST_CNT_HI: begin
            if (rx_valid_i) begin
               if (n_words == 16'd0 || n_words > 16'(MAX_WORDS)) begin
                  state_d = ST_ERR;
               end else begin
                  rem_d   = n_words[12:0];
                  addr_d  = '0;
                  idx_d   = '0;
                  state_d = ST_DATA;
               end
            end else if (expired) begin
               state_d = ST_ERR;
            end
         end
         ST_DATA: begin
            if (rem_q == 13'd0) begin
               state_d = ST_DONE;
            end else if (rx_valid_i) begin
               idx_d = idx_q + 2'd1;
               unique case (idx_q)
                  2'd0: asm_d[7:0]   = rx_data_i;
                  2'd1: asm_d[15:8]  = rx_data_i;
                  2'd2: asm_d[23:16] = rx_data_i;
                  default: begin
                     dat_d   = {rx_data_i, asm_q};
                     waddr_d = {tgt_q, addr_q};
                     wen_d   = 1'b1;
                     addr_d  = addr_q + 14'd4;
                     rem_d   = rem_q - 13'd1;
                  end
               endcase
            end else if (expired) begin
               state_d = ST_ERR;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
      busy_d = (state_d == ST_CNT_LO) || (state_d == ST_CNT_HI) ||
               (state_d == ST_DATA);
      done_d = (state_d == ST_DONE);
      err_d  = (state_d == ST_ERR);
   end

   // State and registered outputs.
   always_ff @(posedge upg_clk_i) begin
      if (!upg_rstn_i) begin
         state_q  <= ST_IDLE;
         tgt_q    <= 1'b0;
         cnt_lo_q <= '0;
         rem_q    <= '0;
         addr_q   <= '0;
         idx_q    <= '0;
         asm_q    <= '0;
         waddr_q  <= '0;
         dat_q    <= '0;
         wen_q    <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tgt_q    <= tgt_d;
         cnt_lo_q <= cnt_lo_d;
         rem_q    <= rem_d;
         addr_q   <= addr_d;
         idx_q    <= idx_d;
         asm_q    <= asm_d;
         waddr_q  <= waddr_d;
         dat_q    <= dat_d;
         wen_q    <= wen_d;
         done_q   <= done_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   uart_upg_loader_if bus ();

   assign bus.wen  = wen_q;
   assign bus.addr = waddr_q;
   assign bus.dat  = dat_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;
   assign bus.busy = busy_q;

   assign upg_wen_o  = bus.wen;
   assign upg_addr_o = bus.addr;
   assign upg_dat_o  = bus.dat;
   assign upg_done_o = bus.done;
   assign err_o      = bus.err;
   assign busy_o     = bus.busy;

endmodule

// File: tb/tb_uart_upg_loader.sv
// Bench for uart_upg_loader: frame table, timeout and streaming reset.
// Expected writes are queued at drive time and popped on each strobe.
module tb_uart_upg_loader;
   import upg_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        wen;
   logic [14:0] addr;
   logic [31:0] dat;
   logic        done;
   logic        err;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   typedef struct packed {
      logic [14:0] a;
      logic [31:0] d;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      string              nm;
      logic [0:11][7:0]   b;
      int                 n;
      int                 nw;
      logic [0:1][14:0]   a;
      logic [0:1][31:0]   d;
      logic               done;
      logic               err;
   } vec_t;

   vec_t vec[5];

   uart_upg_loader #(
      .TIMEOUT_CYCLES(16),
      .MAX_WORDS     (4096)
   ) dut (
      .upg_clk_i (clk),
      .upg_rstn_i(rstn),
      .rx_valid_i(rx_valid),
      .rx_data_i (rx_data),
      .upg_wen_o (wen),
      .upg_addr_o(addr),
      .upg_dat_o (dat),
      .upg_done_o(done),
      .err_o     (err),
      .busy_o    (busy)
   );

   uart_upg_loader_if mon ();

   assign mon.wen  = wen;
   assign mon.addr = addr;
   assign mon.dat  = dat;
   assign mon.done = done;
   assign mon.err  = err;
   assign mon.busy = busy;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rstn     = 1'b0;
      repeat (2) @(negedge clk);
      rstn   = 1'b1;
      pulses = 0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
   endtask

   function automatic logic [31:0] wd(input int i);
      return {8'hA5, 8'(i), 8'(~i), 8'h3C};
   endfunction

   logic wen_p = 1'b0;
   logic done_p = 1'b0;

   // Strobe monitor: pop the scoreboard on every write pulse.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon.wen === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_wen: addr %h dat %h, none expected",
                        mon.addr, mon.dat);
            end else begin
               e = sb.pop_front();
               check("wen_addr_dat", {17'd0, mon.addr, mon.dat},
                     {17'd0, e.a, e.d});
            end
         end
         if (mon.done === 1'b1 && done_p === 1'b0)
            check("done_after_wen", {62'd0, wen_p, mon.wen}, 64'd2);
         wen_p  = mon.wen;
         done_p = mon.done;
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      logic [31:0] w;

      vec[0] = '{nm: "dmem",
                 b: {8'h01, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                     8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00},
                 n: 11, nw: 2,
                 a: {15'h4000, 15'h4004},
                 d: {32'h11223344, 32'hDEADBEEF},
                 done: 1'b1, err: 1'b0};
      vec[1] = '{nm: "badtgt_imem",
                 b: {8'h07, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34,
                     8'h12, 8'h00, 8'h00, 8'h00, 8'h00},
                 n: 8, nw: 1,
                 a: {15'h0000, 15'h0000},
                 d: {32'h12345678, 32'h0},
                 done: 1'b1, err: 1'b0};
      vec[2] = '{nm: "n_zero",
                 b: {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 n: 3, nw: 0,
                 a: {15'h0, 15'h0}, d: {32'h0, 32'h0},
                 done: 1'b0, err: 1'b1};
      vec[3] = '{nm: "n_4097",
                 b: {8'h01, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 n: 3, nw: 0,
                 a: {15'h0, 15'h0}, d: {32'h0, 32'h0},
                 done: 1'b0, err: 1'b1};
      vec[4] = '{nm: "done_ignores",
                 b: {8'h00, 8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01,
                     8'h00, 8'h01, 8'h00, 8'h55, 8'h66},
                 n: 12, nw: 1,
                 a: {15'h0000, 15'h0}, d: {32'h01020304, 32'h0},
                 done: 1'b1, err: 1'b0};

      rstn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rx_valid = 1'($urandom_range(0, 1));
         rx_data  = 8'($urandom);
         @(negedge clk);
         check($sformatf("reset_outputs_%0d", i),
               {13'd0, wen, addr, dat, done, err, busy}, 64'd0);
      end
      rx_valid = 1'b0;
      rstn     = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         do_reset();
         for (int k = 0; k < vec[v].nw; k++)
            sb.push_back({vec[v].a[k], vec[v].d[k]});
         for (int k = 0; k < vec[v].n; k++) send(vec[v].b[k]);
         idle(3);
         check($sformatf("%s_done", vec[v].nm), 64'(done), 64'(vec[v].done));
         check($sformatf("%s_err", vec[v].nm), 64'(err), 64'(vec[v].err));
         check($sformatf("%s_busy", vec[v].nm), 64'(busy), 64'd0);
         check($sformatf("%s_pulses", vec[v].nm), 64'(pulses),
               64'(vec[v].nw));
         check($sformatf("%s_sb_empty", vec[v].nm), 64'(sb.size()), 64'd0);
      end

      do_reset();
      send(8'h01);
      send(8'h01);
      send(8'h00);
      send(8'hAA);
      send(8'hBB);
      rx_valid = 1'b0;
      check("tmo_busy", 64'(busy), 64'd1);
      repeat (15) @(negedge clk);
      check("tmo_err_at_15", 64'(err), 64'd0);
      @(negedge clk);
      check("tmo_err_at_16", 64'(err), 64'd1);
      check("tmo_done", 64'(done), 64'd0);
      check("tmo_busy_off", 64'(busy), 64'd0);
      check("tmo_pulses", 64'(pulses), 64'd0);

      do_reset();
      for (int i = 0; i < 10; i++)
         sb.push_back({15'h4000 + 15'(4 * i), wd(i)});
      send(8'h01);
      send(8'h40);
      send(8'h00);
      for (int i = 0; i < 10; i++) send_word(wd(i));
      w = wd(10);
      send(w[7:0]);
      send(w[15:8]);
      rx_valid = 1'b0;
      rstn     = 1'b0;
      @(negedge clk);
      check("strm_reset_outputs",
            {13'd0, wen, addr, dat, done, err, busy}, 64'd0);
      @(negedge clk);
      check("strm_pulses", 64'(pulses), 64'd10);
      check("strm_sb_empty", 64'(sb.size()), 64'd0);
      rstn   = 1'b1;
      pulses = 0;
      @(negedge clk);
      sb.push_back({15'h4000, 32'hCAFEF00D});
      send(8'h01);
      send(8'h01);
      send(8'h00);
      send_word(32'hCAFEF00D);
      idle(3);
      check("fresh_done", 64'(done), 64'd1);
      check("fresh_err", 64'(err), 64'd0);
      check("fresh_pulses", 64'(pulses), 64'd1);
      check("fresh_sb_empty", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
